// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory sequencer.
// Latches a load/store from EX/MEM, holds the request stable until the
// memory responds, then releases the pipeline for exactly one cycle.
// Also aligns byte loads and counts stall cycles.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        byte_op_in,
  input  logic [15:0] addr_in,
  input  logic [15:0] wdata_in,
  input  logic        dmem_resp,
  input  logic [15:0] dmem_rdata,
  input  logic        stall_clr,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [15:0] dmem_address,
  output logic [15:0] dmem_wdata,
  output logic [1:0]  dmem_byte_enable,
  output logic        pipe_advance,
  output logic [15:0] load_data,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Attributes of the in-flight access, captured when it leaves IDLE.
  typedef struct packed {
    logic write;   // store (a simultaneous read request is dropped)
    logic byte_op; // LDB/STB
    logic hi;      // byte access targets the high lane
  } req_t;

  state_t state, state_nxt;
  req_t   req;
  logic   op_req;

  assign op_req = mem_read_in | mem_write_in;

  // State register; reset aborts any outstanding access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: DONE always returns to IDLE and never looks at new input.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (op_req) state_nxt = BUSY;
      BUSY:    if (dmem_resp) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: strobes only while BUSY; the pipeline moves on no-op or completion.
  always_comb begin
    dmem_read    = (state == BUSY) && !req.write;
    dmem_write   = (state == BUSY) &&  req.write;
    pipe_advance = !rst && (((state == IDLE) && !op_req) || (state == DONE));
  end

  // Capture the request so the memory sees stable values while EX/MEM may change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req              <= '0;
      dmem_address     <= '0;
      dmem_wdata       <= '0;
      dmem_byte_enable <= '0;
    end else if ((state == IDLE) && op_req) begin
      req.write        <= mem_write_in;
      req.byte_op      <= byte_op_in;
      req.hi           <= addr_in[0];
      dmem_address     <= {addr_in[15:1], 1'b0};
      dmem_wdata       <= byte_op_in ? {wdata_in[7:0], wdata_in[7:0]} : wdata_in;
      dmem_byte_enable <= !byte_op_in ? 2'b11 : (addr_in[0] ? 2'b10 : 2'b01);
    end
  end

  // Load result: aligned and zero-extended for bytes; stores leave it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_data <= '0;
    end else if ((state == BUSY) && dmem_resp && !req.write) begin
      if (!req.byte_op) load_data <= dmem_rdata;
      else if (req.hi)  load_data <= {8'h00, dmem_rdata[15:8]};
      else              load_data <= {8'h00, dmem_rdata[7:0]};
    end
  end

  // Stall counter: clear wins over increment; saturates at all ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         stall_count <= '0;
    else if (stall_clr)                              stall_count <= '0;
    else if (!pipe_advance && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed stimulus, transaction-level reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_in, mem_write_in, byte_op_in;
  logic [15:0] addr_in, wdata_in;
  logic        dmem_resp;
  logic [15:0] dmem_rdata;
  logic        stall_clr;
  logic        dmem_read, dmem_write;
  logic [15:0] dmem_address, dmem_wdata;
  logic [1:0]  dmem_byte_enable;
  logic        pipe_advance;
  logic [15:0] load_data, stall_count;

  int n_chk  = 0;
  int n_fail = 0;
  bit run    = 0;

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .byte_op_in(byte_op_in),
    .addr_in(addr_in), .wdata_in(wdata_in),
    .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata), .stall_clr(stall_clr),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
    .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable),
    .pipe_advance(pipe_advance), .load_data(load_data), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (one transaction at a time) ----------------
  bit          m_busy, m_resp, m_wr, m_byte, m_hi;
  logic [15:0] m_addr, m_wdata, m_ld, m_stall;
  logic [1:0]  m_be;

  function automatic bit exp_adv();
    // pipeline moves when nothing is pending and no op is offered, or the op completed
    return !rst && (m_resp || (!m_busy && !(mem_read_in || mem_write_in)));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0; m_resp <= 0; m_wr <= 0; m_byte <= 0; m_hi <= 0;
      m_addr <= 0; m_wdata <= 0; m_ld <= 0; m_stall <= 0; m_be <= 0;
    end else begin
      if (stall_clr) m_stall <= 0;
      else if (!exp_adv() && m_stall != 16'hFFFF) m_stall <= m_stall + 1;
      if (!m_busy) begin
        if (mem_read_in || mem_write_in) begin
          m_busy  <= 1;
          m_wr    <= mem_write_in;
          m_byte  <= byte_op_in;
          m_hi    <= addr_in[0];
          m_addr  <= addr_in & 16'hFFFE;
          m_wdata <= byte_op_in ? (wdata_in & 16'h00FF) * 16'h0101 : wdata_in;
          m_be    <= byte_op_in ? (addr_in[0] ? 2'd2 : 2'd1) : 2'd3;
        end
      end else if (!m_resp) begin
        if (dmem_resp) begin
          m_resp <= 1;
          if (!m_wr)
            m_ld <= m_byte ? ((dmem_rdata >> (m_hi ? 8 : 0)) & 16'h00FF) : dmem_rdata;
        end
      end else begin
        m_busy <= 0;
        m_resp <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("model pipe_advance", pipe_advance, exp_adv());
      chk("model dmem_read", dmem_read, m_busy && !m_resp && !m_wr);
      chk("model dmem_write", dmem_write, m_busy && !m_resp && m_wr);
      chk("model dmem_address", dmem_address, m_addr);
      chk("model dmem_wdata", dmem_wdata, m_wdata);
      chk("model byte_enable", dmem_byte_enable, m_be);
      chk("model load_data", load_data, m_ld);
      chk("model stall_count", stall_count, m_stall);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // single-BUSY-cycle load; returns to IDLE with inputs quiet
  task automatic load1(input logic [15:0] a, input logic b, input logic [15:0] d);
    mem_read_in = 1; byte_op_in = b; addr_in = a;
    step();
    dmem_resp = 1; dmem_rdata = d;
    step();
    dmem_resp = 0; mem_read_in = 0; byte_op_in = 0;
    #1 chk("load1 done pulse", pipe_advance, 1);
    step();
  endtask

  initial begin
    rst = 1; mem_read_in = 0; mem_write_in = 0; byte_op_in = 0;
    addr_in = 0; wdata_in = 0; dmem_resp = 0; dmem_rdata = 0; stall_clr = 0;
    #1;
    chk("reset dmem_read", dmem_read, 0);
    chk("reset dmem_write", dmem_write, 0);
    chk("reset dmem_address", dmem_address, 0);
    chk("reset dmem_wdata", dmem_wdata, 0);
    chk("reset byte_enable", dmem_byte_enable, 0);
    chk("reset pipe_advance", pipe_advance, 0);
    chk("reset load_data", load_data, 0);
    chk("reset stall_count", stall_count, 0);
    run = 1;
    step(); step();
    rst = 0;

    // no-op stream, with stray responses that must be ignored
    for (int i = 0; i < 10; i++) begin
      dmem_resp = (i % 2 == 1); dmem_rdata = 16'hDEAD;
      #1 chk("noop pipe_advance", pipe_advance, 1);
      step();
    end
    dmem_resp = 0;
    chk("noop stall_count", stall_count, 0);
    chk("noop load_data", load_data, 0);

    // word load, response on the third BUSY cycle
    mem_read_in = 1; addr_in = 16'h3005;
    #1 chk("wl idle advance", pipe_advance, 0);
    step(); step(); step();
    chk("wl address", dmem_address, 16'h3004);
    chk("wl byte_enable", dmem_byte_enable, 2'b11);
    chk("wl dmem_read", dmem_read, 1);
    chk("wl busy advance", pipe_advance, 0);
    dmem_resp = 1; dmem_rdata = 16'hBEEF;
    step();
    dmem_resp = 0; mem_read_in = 0; dmem_rdata = 0;
    #1 chk("wl done advance", pipe_advance, 1);
    chk("wl load_data", load_data, 16'hBEEF);
    chk("wl strobe off", dmem_read, 0);
    step();
    chk("wl stall_count", stall_count, 16'd4);

    // byte store to high lane
    mem_write_in = 1; byte_op_in = 1; addr_in = 16'h1001; wdata_in = 16'h12AB;
    step();
    chk("bs dmem_write", dmem_write, 1);
    chk("bs dmem_read", dmem_read, 0);
    chk("bs byte_enable", dmem_byte_enable, 2'b10);
    chk("bs dmem_wdata", dmem_wdata, 16'hABAB);
    chk("bs address", dmem_address, 16'h1000);
    dmem_resp = 1; dmem_rdata = 16'h5555;
    step();
    dmem_resp = 0; mem_write_in = 0; byte_op_in = 0;
    #1 chk("bs load_data kept", load_data, 16'hBEEF);
    step();

    // byte loads, both lanes
    load1(16'h2000, 1, 16'h80F3);
    chk("bl lo load_data", load_data, 16'h00F3);
    load1(16'h2001, 1, 16'h80F3);
    chk("bl hi load_data", load_data, 16'h0080);

    // reset in the second BUSY cycle aborts the access
    mem_read_in = 1; addr_in = 16'h4000;
    step(); step();
    rst = 1;
    #1;
    chk("abort dmem_read", dmem_read, 0);
    chk("abort address", dmem_address, 0);
    chk("abort byte_enable", dmem_byte_enable, 0);
    chk("abort pipe_advance", pipe_advance, 0);
    chk("abort load_data", load_data, 0);
    chk("abort stall_count", stall_count, 0);
    step();
    rst = 0; mem_read_in = 0;
    load1(16'h4002, 0, 16'h1234);
    chk("post-abort load_data", load_data, 16'h1234);
    chk("post-abort stall_count", stall_count, 16'd2);

    // read+write together, address change in BUSY, counter saturation and clear
    stall_clr = 1; mem_read_in = 1; mem_write_in = 1; addr_in = 16'h5006; wdata_in = 16'h7777;
    step();
    stall_clr = 0;
    chk("rw dmem_write", dmem_write, 1);
    chk("rw dmem_read", dmem_read, 0);
    chk("rw stall cleared", stall_count, 0);
    addr_in = 16'hFFFF; wdata_in = 16'h0000;
    step();
    chk("rw address stable", dmem_address, 16'h5006);
    chk("rw wdata stable", dmem_wdata, 16'h7777);
    repeat (65540) step();
    chk("sat stall_count", stall_count, 16'hFFFF);
    stall_clr = 1;
    step();
    stall_clr = 0;
    chk("clr stall_count", stall_count, 0);
    step();
    chk("clr then count", stall_count, 16'd1);
    dmem_resp = 1; dmem_rdata = 16'hAAAA;
    step();
    dmem_resp = 0; mem_read_in = 0; mem_write_in = 0;
    #1 chk("rw done advance", pipe_advance, 1);
    chk("rw load_data kept", load_data, 16'h1234);
    step(); step();

    run = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
